// File: rtl/ov_cfg_pkg.sv
// rtl/ov_cfg_pkg.sv - shared FSM encoding and SCCB frame constants for the register-config stage
package ov_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_BYTE  = 3'd2,
      ST_STOP  = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } cfg_state_t;

   // quarter-bit phases inside every START / bit / STOP slot
   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   // 8 data bits plus the ACK slot, four bytes per register write
   localparam int FRAME_BITS = 9;
   localparam int BYTE_CNT   = 4;

   localparam logic [3:0] ACK_BIT   = 4'(FRAME_BITS - 1);
   localparam logic [3:0] DATA_LAST = 4'(FRAME_BITS - 2);
   localparam logic [1:0] LAST_BYTE = 2'(BYTE_CNT - 1);

   // quarter counter only runs while a frame or gap is in progress
   function automatic logic is_active(input cfg_state_t s);
      return (s != ST_IDLE) && (s != ST_DONE);
   endfunction

endpackage

// File: rtl/ov_sccb_cfg_if.sv
// rtl/ov_sccb_cfg_if.sv - SCCB 3-wire pin bundle between config master and pad/slave
interface ov_sccb_cfg_if;

   logic sioc;
   logic siod_o;
   logic siod_oe;
   logic siod_i;

   modport master (
      output sioc,
      output siod_o,
      output siod_oe,
      input  siod_i
   );

   modport slave (
      input  sioc,
      input  siod_o,
      input  siod_oe,
      output siod_i
   );

endinterface

// File: rtl/ov_reg_rom.sv
// rtl/ov_reg_rom.sv - sensor register table, {reg_addr[15:0], reg_data[7:0]} per index
module ov_reg_rom (
   input  logic [7:0]  i_rom_addr,
   output logic [23:0] o_rom_data
);

   // combinational lookup; swap this file for another sensor variant
   always_comb begin
      o_rom_data = 24'h000000;
      case (i_rom_addr)
         8'd0:    o_rom_data = 24'h3008_82;
         8'd1:    o_rom_data = 24'h3103_03;
         8'd2:    o_rom_data = 24'h3017_FF;
         default: o_rom_data = 24'h000000;
      endcase
   end

endmodule

// File: rtl/ov_sccb_cfg.sv
// rtl/ov_sccb_cfg.sv - walks the register table and issues one SCCB 3-phase write per entry
module ov_sccb_cfg #(
   parameter int         SCCB_DIV = 250,
   parameter int         REG_NUM  = 256,
   parameter logic [7:0] DEV_ID   = 8'h78,
   parameter int         GAP_Q    = 40,
   parameter int         RETRY    = 3
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_init_en,
   output logic [7:0]         o_rom_addr,
   input  logic [23:0]        i_rom_data,
   ov_sccb_cfg_if.master      sccb,
   output logic               o_cfg_busy,
   output logic               o_cfg_done,
   output logic               o_cfg_err
);

   import ov_cfg_pkg::*;

   localparam int             CW     = (SCCB_DIV > 1) ? $clog2(SCCB_DIV) : 1;
   localparam logic [CW-1:0]  C_LAST = CW'(SCCB_DIV - 1);
   localparam int             GW     = (GAP_Q > 1) ? $clog2(GAP_Q) : 1;
   localparam logic [GW-1:0]  G_LAST = GW'(GAP_Q - 1);
   localparam int             RW     = (RETRY > 0) ? $clog2(RETRY + 1) : 1;
   localparam logic [RW-1:0]  R_MAX  = RW'(RETRY);
   localparam logic [7:0]     A_LAST = 8'(REG_NUM - 1);

   cfg_state_t    r_state;
   logic [CW-1:0] r_qcnt;
   logic [1:0]    r_q;
   logic [3:0]    r_bit;
   logic [1:0]    r_byte;
   logic [GW-1:0] r_gap;
   logic [RW-1:0] r_retry;
   logic [23:0]   r_shift;
   logic [7:0]    r_rom_addr;
   logic          r_nack;
   logic          r_fin_ok;
   logic          r_fin_err;
   logic          r_sioc;
   logic          r_siod_o;
   logic          r_siod_oe;
   logic          r_busy;
   logic          r_done;
   logic          r_err;

   logic          w_active;
   logic          w_qtick;
   logic [7:0]    w_dev_id;

   assign w_active = is_active(r_state);
   assign w_qtick  = w_active && (r_qcnt == C_LAST);
   assign w_dev_id = DEV_ID;

   // quarter-bit prescaler, parked at zero whenever no frame/gap is running
   always_ff @(posedge i_clk) begin
      if (i_rst || !w_active || w_qtick) begin
         r_qcnt <= '0;
      end else begin
         r_qcnt <= r_qcnt + 1'b1;
      end
   end

   // frame sequencer: pins and state advance only on the quarter tick,
   // except leaving IDLE and the init_en abort which act immediately
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_q        <= Q0;
         r_bit      <= 4'd0;
         r_byte     <= 2'd0;
         r_gap      <= '0;
         r_retry    <= '0;
         r_shift    <= 24'd0;
         r_rom_addr <= 8'd0;
         r_nack     <= 1'b0;
         r_fin_ok   <= 1'b0;
         r_fin_err  <= 1'b0;
         r_sioc     <= 1'b1;
         r_siod_o   <= 1'b1;
         r_siod_oe  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else if (w_active && !i_init_en) begin
         // sequencer withdrew power-good: release the bus, restart from entry 0 later
         r_state    <= ST_IDLE;
         r_q        <= Q0;
         r_retry    <= '0;
         r_rom_addr <= 8'd0;
         r_nack     <= 1'b0;
         r_fin_ok   <= 1'b0;
         r_fin_err  <= 1'b0;
         r_sioc     <= 1'b1;
         r_siod_o   <= 1'b1;
         r_siod_oe  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_init_en && !r_done && !r_err) begin
                  r_state   <= ST_START;
                  r_q       <= Q0;
                  r_shift   <= i_rom_data;
                  r_nack    <= 1'b0;
                  r_sioc    <= 1'b1;
                  r_siod_o  <= 1'b1;
                  r_siod_oe <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end

            ST_START: begin
               if (w_qtick) begin
                  case (r_q)
                     Q0: begin
                        r_q      <= Q1;
                        r_siod_o <= 1'b0;
                     end
                     Q1: r_q <= Q2;
                     Q2: begin
                        r_q    <= Q3;
                        r_sioc <= 1'b0;
                     end
                     default: begin
                        r_state  <= ST_BYTE;
                        r_q      <= Q0;
                        r_byte   <= 2'd0;
                        r_bit    <= 4'd0;
                        r_siod_o <= w_dev_id[7];
                     end
                  endcase
               end
            end

            ST_BYTE: begin
               if (w_qtick) begin
                  case (r_q)
                     Q0: begin
                        r_q    <= Q1;
                        r_sioc <= 1'b1;
                     end
                     Q1: r_q <= Q2;
                     Q2: begin
                        r_q    <= Q3;
                        r_sioc <= 1'b0;
                        // slave holds ACK low mid-high-phase; a high here is a NACK
                        if (r_bit == ACK_BIT && sccb.siod_i) begin
                           r_nack <= 1'b1;
                        end
                     end
                     default: begin
                        r_q <= Q0;
                        if (r_bit == ACK_BIT) begin
                           r_siod_oe <= 1'b1;
                           if (r_byte == LAST_BYTE) begin
                              r_state  <= ST_STOP;
                              r_siod_o <= 1'b0;
                           end else begin
                              r_byte   <= r_byte + 1'b1;
                              r_bit    <= 4'd0;
                              r_siod_o <= r_shift[23];
                              r_shift  <= {r_shift[22:0], 1'b0};
                           end
                        end else if (r_bit == DATA_LAST) begin
                           r_bit     <= ACK_BIT;
                           r_siod_oe <= 1'b0;
                        end else begin
                           r_bit <= r_bit + 1'b1;
                           if (r_byte == 2'd0) begin
                              r_siod_o <= w_dev_id[3'd6 - r_bit[2:0]];
                           end else begin
                              r_siod_o <= r_shift[23];
                              r_shift  <= {r_shift[22:0], 1'b0};
                           end
                        end
                     end
                  endcase
               end
            end

            ST_STOP: begin
               if (w_qtick) begin
                  case (r_q)
                     Q0: begin
                        r_q    <= Q1;
                        r_sioc <= 1'b1;
                     end
                     Q1: begin
                        r_q      <= Q2;
                        r_siod_o <= 1'b1;
                     end
                     Q2: r_q <= Q3;
                     default: begin
                        r_state <= ST_GAP;
                        r_q     <= Q0;
                        r_gap   <= '0;
                        // frame verdict: retry same entry, advance, or finish
                        if (r_nack) begin
                           if (r_retry == R_MAX) begin
                              r_fin_err <= 1'b1;
                           end else begin
                              r_retry <= r_retry + 1'b1;
                           end
                        end else begin
                           r_retry <= '0;
                           if (r_rom_addr == A_LAST) begin
                              r_fin_ok <= 1'b1;
                           end else begin
                              r_rom_addr <= r_rom_addr + 8'd1;
                           end
                        end
                     end
                  endcase
               end
            end

            ST_GAP: begin
               if (w_qtick) begin
                  if (r_gap == G_LAST) begin
                     if (r_fin_err || r_fin_ok) begin
                        r_state   <= ST_DONE;
                        r_err     <= r_fin_err;
                        r_done    <= r_fin_ok && !r_fin_err;
                        r_busy    <= 1'b0;
                        r_siod_oe <= 1'b0;
                        r_sioc    <= 1'b1;
                        r_siod_o  <= 1'b1;
                     end else begin
                        r_state   <= ST_START;
                        r_q       <= Q0;
                        r_shift   <= i_rom_data;
                        r_nack    <= 1'b0;
                        r_sioc    <= 1'b1;
                        r_siod_o  <= 1'b1;
                        r_siod_oe <= 1'b1;
                     end
                  end else begin
                     r_gap <= r_gap + 1'b1;
                  end
               end
            end

            ST_DONE: begin
               r_state <= ST_DONE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign sccb.sioc    = r_sioc;
   assign sccb.siod_o  = r_siod_o;
   assign sccb.siod_oe = r_siod_oe;
   assign o_rom_addr   = r_rom_addr;
   assign o_cfg_busy   = r_busy;
   assign o_cfg_done   = r_done;
   assign o_cfg_err    = r_err;

endmodule

// File: tb/tb_ov_sccb_cfg.sv
// tb/tb_ov_sccb_cfg.sv - directed bench with SCCB slave decoder for ov_sccb_cfg
module tb_ov_sccb_cfg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        init_en = 1'b0;
   logic [7:0]  rom_addr;
   logic [23:0] rom_data;
   logic        busy;
   logic        done;
   logic        err;

   ov_sccb_cfg_if sccb_if ();

   logic slave_low = 1'b0;
   logic w_line;
   assign w_line         = sccb_if.siod_oe ? sccb_if.siod_o : ~slave_low;
   assign sccb_if.siod_i = w_line;

   ov_sccb_cfg #(
      .SCCB_DIV (4),
      .REG_NUM  (3),
      .DEV_ID   (8'h78),
      .GAP_Q    (2),
      .RETRY    (1)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_init_en  (init_en),
      .o_rom_addr (rom_addr),
      .i_rom_data (rom_data),
      .sccb       (sccb_if.master),
      .o_cfg_busy (busy),
      .o_cfg_done (done),
      .o_cfg_err  (err)
   );

   ov_reg_rom rom (
      .i_rom_addr (rom_addr),
      .o_rom_data (rom_data)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;

   int         bib       = 0;
   int         byte_idx  = 0;
   int         frame_no  = 0;
   int         tviol     = 0;
   int         nack_mode = 0;
   int         clr_req   = 0;
   int         clr_ack   = 0;
   logic       in_frame  = 1'b0;
   logic       prev_scl  = 1'b1;
   logic       prev_sda  = 1'b1;
   logic [7:0] cur       = 8'h00;
   logic [7:0] frame_bytes [4];
   logic [7:0] byte_q [$];
   logic [7:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic nack_now();
      if (byte_idx != 3) return 1'b0;
      if (nack_mode == 1) return (frame_no == 0);
      if (nack_mode == 2) return (frame_bytes[1] == 8'h31);
      return 1'b0;
   endfunction

   // slave model: decodes START/STOP/bits, ACKs bytes, flags SDA moving while SCL high
   always @(negedge clk) begin
      if (clr_req != clr_ack) begin
         clr_ack   = clr_req;
         in_frame  = 1'b0;
         bib       = 0;
         byte_idx  = 0;
         frame_no  = 0;
         tviol     = 0;
         slave_low = 1'b0;
         byte_q.delete();
         prev_scl  = sccb_if.sioc;
         prev_sda  = w_line;
      end else begin
         if (prev_scl && sccb_if.sioc && (w_line != prev_sda)) begin
            if (!w_line && !in_frame) begin
               in_frame = 1'b1;
               bib      = 0;
               byte_idx = 0;
            end else if (w_line && in_frame && byte_idx == 4 && bib == 0) begin
               in_frame = 1'b0;
               frame_no++;
            end else begin
               tviol++;
            end
         end else if (!prev_scl && sccb_if.sioc && in_frame && byte_idx < 4) begin
            bib++;
            if (bib <= 8) cur = {cur[6:0], w_line};
            if (bib == 8) begin
               byte_q.push_back(cur);
               frame_bytes[byte_idx] = cur;
            end
         end else if (prev_scl && !sccb_if.sioc && in_frame && bib == 9) begin
            bib = 0;
            byte_idx++;
         end
         slave_low = in_frame && (bib == 8 || bib == 9) && !nack_now();
         prev_scl  = sccb_if.sioc;
         prev_sda  = w_line;
      end
   end

   task automatic do_reset();
      init_en = 1'b0;
      rst     = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      clr_req++;
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_stream(input string tag);
      logic [31:0] got;
      chk({tag, "_len"}, byte_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
         got = (i < byte_q.size()) ? {24'd0, byte_q[i]} : 32'hFFFF;
         chk($sformatf("%s_b%0d", tag, i), got, {24'd0, exp_q[i]});
      end
   endtask

   task automatic wait_end(input int limit);
      int cyc;
      cyc = 0;
      while (!done && !err && cyc < limit) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      int   cyc;
      logic reached;

      // 1: idle after reset with init_en low
      do_reset();
      repeat (100) @(posedge clk);
      #1;
      chk("t1_sioc", sccb_if.sioc, 1);
      chk("t1_oe", sccb_if.siod_oe, 0);
      chk("t1_busy", busy, 0);
      chk("t1_addr", rom_addr, 0);
      chk("t1_flags", {done, err}, 0);

      // 2: full table, no NACK, completion time
      nack_mode = 0;
      init_en   = 1'b1;
      @(posedge clk);
      #1;
      chk("t2_busy_next", busy, 1);
      cyc = 1;
      while (!done && cyc < 4000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("t2_done", done, 1);
      chk("t2_cycles", (cyc >= 1844 && cyc <= 1852) ? 32'd1848 : cyc, 1848);
      chk("t2_err", err, 0);
      chk("t2_busy", busy, 0);
      chk("t2_addr", rom_addr, 2);
      chk("t2_pins", {sccb_if.sioc, sccb_if.siod_oe}, 2'b10);
      chk("t2_frames", frame_no, 3);
      chk("t2_timing", tviol, 0);
      exp_q = '{8'h78, 8'h30, 8'h08, 8'h82, 8'h78, 8'h31, 8'h03, 8'h03,
                8'h78, 8'h30, 8'h17, 8'hFF};
      chk_stream("t2");

      // 3: one NACK on entry 0 data byte -> resend then complete
      do_reset();
      nack_mode = 1;
      init_en   = 1'b1;
      cyc = 0;
      while (frame_no < 1 && cyc < 2000) begin
         @(posedge clk);
         cyc++;
      end
      repeat (10) @(posedge clk);
      #1;
      chk("t3_addr_hold", rom_addr, 0);
      wait_end(4000);
      chk("t3_done", done, 1);
      chk("t3_err", err, 0);
      chk("t3_addr", rom_addr, 2);
      chk("t3_timing", tviol, 0);
      exp_q = '{8'h78, 8'h30, 8'h08, 8'h82, 8'h78, 8'h30, 8'h08, 8'h82,
                8'h78, 8'h31, 8'h03, 8'h03, 8'h78, 8'h30, 8'h17, 8'hFF};
      chk_stream("t3");

      // 4: entry 1 always NACKed -> sent twice then error
      do_reset();
      nack_mode = 2;
      init_en   = 1'b1;
      wait_end(5000);
      chk("t4_err", err, 1);
      chk("t4_done", done, 0);
      chk("t4_addr", rom_addr, 1);
      chk("t4_busy", busy, 0);
      chk("t4_frames", frame_no, 3);
      chk("t4_timing", tviol, 0);
      exp_q = '{8'h78, 8'h30, 8'h08, 8'h82, 8'h78, 8'h31, 8'h03, 8'h03,
                8'h78, 8'h31, 8'h03, 8'h03};
      chk_stream("t4");

      // 5: init_en dropped during entry 1 byte 2, then restart from entry 0
      do_reset();
      nack_mode = 0;
      init_en   = 1'b1;
      reached   = 1'b0;
      cyc = 0;
      while (!reached && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         reached = (frame_no == 1) && in_frame && (byte_idx == 2);
      end
      chk("t5_reach", reached, 1);
      chk("t5_addr_mid", rom_addr, 1);
      init_en = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_oe", sccb_if.siod_oe, 0);
      chk("t5_addr", rom_addr, 0);
      chk("t5_busy", busy, 0);
      chk("t5_sioc", sccb_if.sioc, 1);
      repeat (5) @(posedge clk);
      clr_req++;
      repeat (2) @(negedge clk);
      init_en = 1'b1;
      cyc = 0;
      while (byte_q.size() < 4 && cyc < 1000) begin
         @(posedge clk);
         cyc++;
      end
      exp_q = '{8'h78, 8'h30, 8'h08, 8'h82};
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t5_b%0d", i), (i < byte_q.size()) ? {24'd0, byte_q[i]} : 32'hFFFF,
             {24'd0, exp_q[i]});
      end
      wait_end(4000);
      chk("t5_done", done, 1);
      chk("t5_timing", tviol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
